cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter NUM_FSETS, default 2, number of independent NZCV flag sets (set 0 = integer ALU, set 1 = FPU); legal range 1..4.
REQ-002 Parameter FSEL_W, default 1, width of FSel; SHALL equal max(1, clog2(NUM_FSETS)).
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Valid  in  1  instruction present at the input; Stall  in  1  hold; Flush  in  1  kill.
REQ-006 PCS, RegW, MemW, FPUW, NoWrite  in  1 each  decoder write/branch requests.
REQ-007 FlagW  in  2  bit1 updates N,Z; bit0 updates C,V.
REQ-008 FSel  in  FSEL_W  flag set read for the condition and written by FlagW.
REQ-009 Cond  in  4  ARM condition field; ALUFlags  in  4  {N,Z,C,V} result.
REQ-010 ITStart  in  1, ITCond  in  4, ITLen  in  3, ITMask  in  4  IT-block descriptor.
REQ-011 PCSrc, RegWrite, MemWrite, FPUWrite, CondExOut, ValidOut  out  1 each  registered decisions.
REQ-012 C  out  1  current carry of flag set 0, unregistered, for ADC/SBC; ITActive  out  1.

Function
REQ-013 Accept = Valid & ~Stall & ~Flush; only accepted instructions update any state.
REQ-014 Conditions 0..13 SHALL decode as EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE against set FSel; 14 (AL) SHALL be true; 15 SHALL be false.
REQ-015 Flag write on accept SHALL occur only if CondEx=1 (per FlagW bit pairs, into set FSel); FSel >= NUM_FSETS SHALL write nothing and read flags as 0.
REQ-016 Outputs SHALL be registered, latency 1: on an accept edge PCSrc=PCS&CondEx, RegWrite=RegW&CondEx&~NoWrite, MemWrite=MemW&CondEx, FPUWrite=FPUW&CondEx, CondExOut=CondEx, ValidOut=1.
REQ-017 Cycle with Flush=1: all registered outputs SHALL go to 0 next edge, no flag write, IT state cleared to IDLE; Flush overrides Stall and Valid.
REQ-018 Stall=1 and Flush=0: registered outputs, flags and IT state SHALL hold.
REQ-019 Valid=0, Stall=0, Flush=0: registered outputs SHALL go to 0 next edge.
REQ-020 Instruction accepted k cycles after another reads flags written by it (no bypass required; flags visible the cycle after the write edge).
REQ-021 IT FSM states IDLE, ACTIVE; 3-bit remaining counter, 2-bit index k.
REQ-022 IDLE: accepted ITStart with ITLen in 1..4 -> ACTIVE, latch ITCond/ITMask, remaining=ITLen, k=0; the IT instruction itself SHALL produce all-zero write outputs with ValidOut=1 and no flag write; ITLen 0 or >4 SHALL be ignored.
REQ-023 ACTIVE: Cond input ignored; effective cond = ITCond for k=0, else ITCond^{3'b0,ITMask[k]}; each accept decrements remaining and increments k; remaining reaching 0 -> IDLE.
REQ-024 ITStart accepted in ACTIVE SHALL be ignored (treated as ordinary instruction).
REQ-025 ITActive SHALL be 1 exactly in ACTIVE.

Reset
REQ-026 Reset SHALL clear all flag sets, all registered outputs, C, counter, index and put FSM in IDLE; Reset overrides Flush, Stall and Valid, including mid-IT-block.

Configuration
REQ-027 Macro COND_IT_EN defined: IT FSM per REQ-021..025 present.
REQ-028 COND_IT_EN undefined: no IT logic; ITStart/ITCond/ITLen/ITMask ignored, ITActive tied 0, Cond always used.

Structure
REQ-029 Package cond_pkg SHALL hold condition-code constants (EQ..AL, NV), flag bit indices N=3,Z=2,C=1,V=0, and the IT state enum.
REQ-030 Sub-module cond_eval (combinational: 4-bit cond + NZCV -> CondEx) SHALL be instantiated once.

Verification
REQ-031 Set0 Z=1 via FlagW=2'b10, ALUFlags=4'b0100; next instr Cond=0, RegW=1 -> RegWrite=1 one cycle later; Cond=1 -> 0.
REQ-032 Cond=0 false, FlagW=2'b11, ALUFlags=4'b1111 -> flags unchanged (N=Z=C=V=0); Cond=15, PCS=1 -> PCSrc=0.
REQ-033 FSel=1 writes C=1, then FSel=0 Cond=2 -> CondExOut=0; FSel=1 Cond=2 -> 1; C output stays 0.
REQ-034 ITStart ITCond=0 ITLen=3 ITMask=4'b0100, Z=1: next three instrs (Cond=14, MemW=1) -> MemWrite 1,1,0; ITActive drops after third accept.
REQ-035 Stall=1 for 2 cycles mid-IT -> outputs and counter hold; Flush next cycle -> ITActive=0, outputs 0.
REQ-036 Reset asserted in ACTIVE with ValidOut=1 -> next edge all outputs 0, ITActive=0, flags 0.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg: shared definitions for the conditional-execution unit.
//   - ARM condition-code encodings (EQ..AL, NV)
//   - NZCV bit positions inside a 4-bit flag word
//   - IT-block FSM state type
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [2:0] IT_MAX_LEN = 3'd4;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition evaluator.
// Ports:
//   cond_i   [3:0]  condition field
//   flags_i  [3:0]  {N,Z,C,V}
//   condex_o        1 when the condition holds
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       condex_o
);

  logic n, z, c, v;

  always_comb begin
    n = flags_i[FLAG_N];
    z = flags_i[FLAG_Z];
    c = flags_i[FLAG_C];
    v = flags_i[FLAG_V];
    condex_o = 1'b0;
    case (cond_i)
      COND_EQ: condex_o = z;
      COND_NE: condex_o = ~z;
      COND_CS: condex_o = c;
      COND_CC: condex_o = ~c;
      COND_MI: condex_o = n;
      COND_PL: condex_o = ~n;
      COND_VS: condex_o = v;
      COND_VC: condex_o = ~v;
      COND_HI: condex_o = c & ~z;
      COND_LS: condex_o = ~c | z;
      COND_GE: condex_o = ~(n ^ v);
      COND_LT: condex_o = n ^ v;
      COND_GT: condex_o = ~z & ~(n ^ v);
      COND_LE: condex_o = z | (n ^ v);
      COND_AL: condex_o = 1'b1;
      default: condex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage with multiple NZCV flag sets and
// an optional Thumb-style IT-block sequencer (enabled by macro COND_IT_EN).
// Ports:
//   CLK, Reset (sync, active-high)
//   Valid / Stall / Flush              pipeline control
//   PCS, RegW, MemW, FPUW, NoWrite     decoder requests
//   FlagW[1:0]                         bit1 -> N,Z ; bit0 -> C,V
//   FSel[FSEL_W-1:0]                   flag set read/written
//   Cond[3:0], ALUFlags[3:0]           condition field, {N,Z,C,V} result
//   ITStart, ITCond, ITLen, ITMask     IT-block descriptor
//   PCSrc, RegWrite, MemWrite, FPUWrite, CondExOut, ValidOut  registered
//   C                                  carry of flag set 0 (from flag reg)
//   ITActive                           1 while inside an IT block
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned NUM_FSETS = 2,
  parameter int unsigned FSEL_W    = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              FPUW,
  input  logic              NoWrite,
  input  logic [1:0]        FlagW,
  input  logic [FSEL_W-1:0] FSel,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic              ITStart,
  input  logic [3:0]        ITCond,
  input  logic [2:0]        ITLen,
  input  logic [3:0]        ITMask,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              FPUWrite,
  output logic              CondExOut,
  output logic              ValidOut,
  output logic              C,
  output logic              ITActive
);

  logic       accept;
  logic [3:0] flags_q [NUM_FSETS];
  logic [3:0] flags_rd;
  logic       fsel_ok;
  logic [3:0] cond_eff;
  logic       condex;
  logic       it_instr;
  logic       it_active;

  logic pcsrc_q, pcsrc_d, regw_q, regw_d, memw_q, memw_d;
  logic fpuw_q, fpuw_d, condex_q, condex_d, valid_q, valid_d;

  assign accept = Valid & ~Stall & ~Flush;

  // Out-of-range FSel reads as all-zero flags and blocks flag writes.
  always_comb begin
    flags_rd = '0;
    fsel_ok  = 1'b0;
    for (int unsigned i = 0; i < NUM_FSETS; i++) begin
      if (FSel == FSEL_W'(i)) begin
        flags_rd = flags_q[i];
        fsel_ok  = 1'b1;
      end
    end
  end

`ifdef COND_IT_EN
  it_state_e  state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [1:0] k_q, k_d;
  logic [3:0] itcond_q, itcond_d, itmask_q, itmask_d;
  logic       it_len_ok;

  assign it_len_ok = (ITLen != 3'd0) && (ITLen <= IT_MAX_LEN);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IT_IDLE;
      rem_q    <= '0;
      k_q      <= '0;
      itcond_q <= '0;
      itmask_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      k_q      <= k_d;
      itcond_q <= itcond_d;
      itmask_q <= itmask_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    k_d      = k_q;
    itcond_d = itcond_q;
    itmask_d = itmask_q;
    if (Flush) begin
      state_d = IT_IDLE;
      rem_d   = '0;
      k_d     = '0;
    end else if (accept) begin
      case (state_q)
        IT_IDLE: begin
          if (ITStart && it_len_ok) begin
            state_d  = IT_ACTIVE;
            rem_d    = ITLen;
            k_d      = '0;
            itcond_d = ITCond;
            itmask_d = ITMask;
          end
        end
        IT_ACTIVE: begin
          rem_d = rem_q - 3'd1;
          k_d   = k_q + 2'd1;
          if (rem_q == 3'd1) state_d = IT_IDLE;
        end
        default: state_d = IT_IDLE;
      endcase
    end
  end

  always_comb begin
    it_active = (state_q == IT_ACTIVE);
    it_instr  = accept && (state_q == IT_IDLE) && ITStart && it_len_ok;
    if (!it_active)
      cond_eff = Cond;
    else if (k_q == 2'd0)
      cond_eff = itcond_q;
    else
      cond_eff = itcond_q ^ {3'b000, itmask_q[k_q]};
  end
`else
  logic unused_it_inputs;
  assign unused_it_inputs = ^{ITStart, ITCond, ITLen, ITMask};
  assign it_active = 1'b0;
  assign it_instr  = 1'b0;
  assign cond_eff  = Cond;
`endif

  cond_eval u_cond_eval (
    .cond_i  (cond_eff),
    .flags_i (flags_rd),
    .condex_o(condex)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_FSETS; i++) flags_q[i] <= '0;
    end else if (accept && condex && !it_instr && fsel_ok) begin
      for (int unsigned i = 0; i < NUM_FSETS; i++) begin
        if (FSel == FSEL_W'(i)) begin
          if (FlagW[1]) begin
            flags_q[i][FLAG_N] <= ALUFlags[FLAG_N];
            flags_q[i][FLAG_Z] <= ALUFlags[FLAG_Z];
          end
          if (FlagW[0]) begin
            flags_q[i][FLAG_C] <= ALUFlags[FLAG_C];
            flags_q[i][FLAG_V] <= ALUFlags[FLAG_V];
          end
        end
      end
    end
  end

  // Flush beats Stall beats Valid. The IT instruction itself is a
  // valid bubble: it reports ValidOut but no writes and no condition.
  always_comb begin
    pcsrc_d  = pcsrc_q;
    regw_d   = regw_q;
    memw_d   = memw_q;
    fpuw_d   = fpuw_q;
    condex_d = condex_q;
    valid_d  = valid_q;
    if (Flush || (!Stall && !Valid)) begin
      pcsrc_d  = 1'b0;
      regw_d   = 1'b0;
      memw_d   = 1'b0;
      fpuw_d   = 1'b0;
      condex_d = 1'b0;
      valid_d  = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      if (it_instr) begin
        pcsrc_d  = 1'b0;
        regw_d   = 1'b0;
        memw_d   = 1'b0;
        fpuw_d   = 1'b0;
        condex_d = 1'b0;
      end else begin
        pcsrc_d  = PCS & condex;
        regw_d   = RegW & condex & ~NoWrite;
        memw_d   = MemW & condex;
        fpuw_d   = FPUW & condex;
        condex_d = condex;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pcsrc_q  <= 1'b0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      fpuw_q   <= 1'b0;
      condex_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      pcsrc_q  <= pcsrc_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      fpuw_q   <= fpuw_d;
      condex_q <= condex_d;
      valid_q  <= valid_d;
    end
  end

  assign PCSrc     = pcsrc_q;
  assign RegWrite  = regw_q;
  assign MemWrite  = memw_q;
  assign FPUWrite  = fpuw_q;
  assign CondExOut = condex_q;
  assign ValidOut  = valid_q;
  assign C         = flags_q[0][FLAG_C];
  assign ITActive  = it_active;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed self-checking bench for cond_unit (default params).
// IT-block scenarios are exercised when COND_IT_EN is defined; otherwise
// the bench checks that the IT inputs have no effect.
module tb_cond_unit;

  logic CLK = 1'b0;
  logic Reset, Valid, Stall, Flush, PCS, RegW, MemW, FPUW, NoWrite;
  logic [1:0] FlagW;
  logic [0:0] FSel;
  logic [3:0] Cond, ALUFlags, ITCond, ITMask;
  logic [2:0] ITLen;
  logic ITStart;
  logic PCSrc, RegWrite, MemWrite, FPUWrite, CondExOut, ValidOut, C, ITActive;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // {PCSrc, RegWrite, MemWrite, FPUWrite, CondExOut, ValidOut}
  assign outs = {PCSrc, RegWrite, MemWrite, FPUWrite, CondExOut, ValidOut};

  cond_unit #(.NUM_FSETS(2), .FSEL_W(1)) dut (
    .CLK(CLK), .Reset(Reset), .Valid(Valid), .Stall(Stall), .Flush(Flush),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FPUW(FPUW), .NoWrite(NoWrite),
    .FlagW(FlagW), .FSel(FSel), .Cond(Cond), .ALUFlags(ALUFlags),
    .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITMask(ITMask),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .FPUWrite(FPUWrite), .CondExOut(CondExOut), .ValidOut(ValidOut),
    .C(C), .ITActive(ITActive)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in;
    Reset = 0; Valid = 0; Stall = 0; Flush = 0;
    PCS = 0; RegW = 0; MemW = 0; FPUW = 0; NoWrite = 0;
    FlagW = 2'b00; FSel = 1'b0; Cond = 4'd14; ALUFlags = 4'd0;
    ITStart = 0; ITCond = 4'd0; ITLen = 3'd0; ITMask = 4'd0;
  endtask

  // One accepted instruction; wr = {PCS, RegW, MemW, FPUW}.
  task automatic instr(input logic [3:0] cnd, input logic [1:0] fw,
                       input logic [3:0] alu, input logic [3:0] wr);
    Reset = 0; Valid = 1; Stall = 0; Flush = 0; NoWrite = 0;
    Cond = cnd; FlagW = fw; ALUFlags = alu;
    {PCS, RegW, MemW, FPUW} = wr;
    tick();
  endtask

  task automatic test_reset;
    clear_in();
    Reset = 1; Valid = 1; PCS = 1; RegW = 1;
    tick(); tick();
    checks++;
    if (outs !== 6'b000000) begin
      errors++; $display("FAIL reset_outs got=%b exp=000000", outs);
    end
    checks++;
    if ({C, ITActive} !== 2'b00) begin
      errors++; $display("FAIL reset_c_it got=%b exp=00", {C, ITActive});
    end
    Reset = 0;
  endtask

  task automatic test_cond_basic;
    clear_in();
    instr(4'd14, 2'b10, 4'b0100, 4'b0000);   // Z=1 in set 0
    checks++;
    if (outs !== 6'b000011) begin
      errors++; $display("FAIL basic_flagset got=%b exp=000011", outs);
    end
    instr(4'd0, 2'b00, 4'b0000, 4'b0100);    // EQ, RegW
    checks++;
    if (outs !== 6'b010011) begin
      errors++; $display("FAIL basic_eq_regw got=%b exp=010011", outs);
    end
    instr(4'd1, 2'b00, 4'b0000, 4'b0100);    // NE, RegW
    checks++;
    if (outs !== 6'b000001) begin
      errors++; $display("FAIL basic_ne_regw got=%b exp=000001", outs);
    end
    NoWrite = 1; Valid = 1; Cond = 4'd0; FlagW = 2'b00;
    {PCS, RegW, MemW, FPUW} = 4'b1101;
    tick();
    checks++;
    if (outs !== 6'b100111) begin
      errors++; $display("FAIL basic_nowrite got=%b exp=100111", outs);
    end
    NoWrite = 0;
  endtask

  task automatic test_cond_table;
    logic [15:0] expv [3];
    logic [3:0]  fl [3];
    logic        e;
    fl[0] = 4'b0110; expv[0] = 16'b0110_0110_1010_0101;
    fl[1] = 4'b1001; expv[1] = 16'b0101_0110_0101_1010;
    fl[2] = 4'b1010; expv[2] = 16'b0110_1001_1001_0110;
    clear_in();
    for (int t = 0; t < 3; t++) begin
      instr(4'd14, 2'b11, fl[t], 4'b0000);
      checks++;
      if (C !== fl[t][1]) begin
        errors++; $display("FAIL table_carry set=%0d got=%b exp=%b", t, C, fl[t][1]);
      end
      for (int c = 0; c < 16; c++) begin
        instr(4'(c), 2'b00, 4'b0000, 4'b0010);
        e = expv[t][c];
        checks++;
        if (outs !== {2'b00, e, 1'b0, e, 1'b1}) begin
          errors++;
          $display("FAIL cond_table flags=%b cond=%0d got=%b exp=%b",
                   fl[t], c, outs, {2'b00, e, 1'b0, e, 1'b1});
        end
      end
    end
  endtask

  task automatic test_false_no_flagwrite;
    clear_in();
    instr(4'd14, 2'b11, 4'b0000, 4'b0000);   // all flags 0
    instr(4'd0, 2'b11, 4'b1111, 4'b0000);    // EQ false: no write
    checks++;
    if (outs !== 6'b000001) begin
      errors++; $display("FAIL false_instr got=%b exp=000001", outs);
    end
    checks++;
    if (C !== 1'b0) begin
      errors++; $display("FAIL false_carry got=%b exp=0", C);
    end
    instr(4'd4, 2'b00, 4'b0000, 4'b0000);    // MI must still be false
    checks++;
    if (CondExOut !== 1'b0) begin
      errors++; $display("FAIL false_n_kept got=%b exp=0", CondExOut);
    end
    instr(4'd15, 2'b00, 4'b0000, 4'b1000);   // NV with PCS
    checks++;
    if (outs !== 6'b000001) begin
      errors++; $display("FAIL nv_pcs got=%b exp=000001", outs);
    end
  endtask

  task automatic test_fsel;
    clear_in();
    instr(4'd14, 2'b11, 4'b0000, 4'b0000);
    FSel = 1'b1;
    instr(4'd14, 2'b01, 4'b0010, 4'b0000);   // set 1: C=1
    checks++;
    if (C !== 1'b0) begin
      errors++; $display("FAIL fsel_c_out got=%b exp=0", C);
    end
    FSel = 1'b0;
    instr(4'd2, 2'b00, 4'b0000, 4'b0000);
    checks++;
    if (CondExOut !== 1'b0) begin
      errors++; $display("FAIL fsel0_cs got=%b exp=0", CondExOut);
    end
    FSel = 1'b1;
    instr(4'd2, 2'b00, 4'b0000, 4'b0001);
    checks++;
    if (outs !== 6'b000111) begin
      errors++; $display("FAIL fsel1_cs got=%b exp=000111", outs);
    end
    checks++;
    if (C !== 1'b0) begin
      errors++; $display("FAIL fsel_c_final got=%b exp=0", C);
    end
    FSel = 1'b0;
  endtask

  task automatic test_stall_flush;
    clear_in();
    instr(4'd14, 2'b11, 4'b0000, 4'b0100);   // flags 0, RegWrite=1
    Stall = 1; Valid = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
    {PCS, RegW, MemW, FPUW} = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== 6'b010011) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%b exp=010011", i, outs);
      end
    end
    Stall = 0; Valid = 0; FlagW = 2'b00;
    tick();
    checks++;
    if (outs !== 6'b000000) begin
      errors++; $display("FAIL idle_bubble got=%b exp=000000", outs);
    end
    checks++;
    if (C !== 1'b0) begin
      errors++; $display("FAIL stall_no_flag got=%b exp=0", C);
    end
    instr(4'd14, 2'b00, 4'b0000, 4'b1111);
    Flush = 1; Stall = 1; Valid = 1;
    tick();
    checks++;
    if (outs !== 6'b000000) begin
      errors++; $display("FAIL flush_outs got=%b exp=000000", outs);
    end
    Flush = 0; Stall = 0;
  endtask

  task automatic test_back_to_back;
    clear_in();
    instr(4'd14, 2'b10, 4'b0100, 4'b0000);   // Z=1
    instr(4'd0, 2'b10, 4'b0000, 4'b0100);    // EQ true, clears Z
    checks++;
    if (outs !== 6'b010011) begin
      errors++; $display("FAIL b2b_first got=%b exp=010011", outs);
    end
    instr(4'd0, 2'b00, 4'b0000, 4'b0100);
    checks++;
    if (outs !== 6'b000001) begin
      errors++; $display("FAIL b2b_second got=%b exp=000001", outs);
    end
  endtask

  task automatic test_reset_override;
    clear_in();
    instr(4'd14, 2'b11, 4'b0110, 4'b0100);   // C=1, outputs active
    Reset = 1; Valid = 1; Stall = 1; Flush = 1;
    tick();
    checks++;
    if ({outs, C} !== 7'b0000000) begin
      errors++; $display("FAIL reset_override got=%b exp=0000000", {outs, C});
    end
    clear_in();
  endtask

`ifdef COND_IT_EN
  task automatic test_it_block;
    logic [2:0] exp_mw;
    logic [2:0] exp_act;
    exp_mw = 3'b011; exp_act = 3'b011;        // index 0 is first instr
    clear_in();
    instr(4'd14, 2'b11, 4'b0100, 4'b0000);   // Z=1 only
    ITStart = 1; ITCond = 4'd0; ITLen = 3'd3; ITMask = 4'b0100;
    instr(4'd14, 2'b00, 4'b0000, 4'b1111);
    checks++;
    if ({PCSrc, RegWrite, MemWrite, FPUWrite, ValidOut, ITActive} !== 6'b000011) begin
      errors++;
      $display("FAIL it_start got=%b exp=000011",
               {PCSrc, RegWrite, MemWrite, FPUWrite, ValidOut, ITActive});
    end
    ITStart = 0;
    for (int i = 0; i < 3; i++) begin
      instr(4'd14, 2'b00, 4'b0000, 4'b0010);
      checks++;
      if ({MemWrite, ITActive} !== {exp_mw[i], exp_act[i]}) begin
        errors++;
        $display("FAIL it_seq idx=%0d got=%b exp=%b", i,
                 {MemWrite, ITActive}, {exp_mw[i], exp_act[i]});
      end
    end
    ITStart = 1; ITLen = 3'd0;
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);
    checks++;
    if ({MemWrite, ITActive} !== 2'b10) begin
      errors++; $display("FAIL it_len0 got=%b exp=10", {MemWrite, ITActive});
    end
    ITLen = 3'd5;
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);
    checks++;
    if ({MemWrite, ITActive} !== 2'b10) begin
      errors++; $display("FAIL it_len5 got=%b exp=10", {MemWrite, ITActive});
    end
    ITLen = 3'd2; ITCond = 4'd0; ITMask = 4'b0000;
    instr(4'd14, 2'b00, 4'b0000, 4'b0000);
    ITLen = 3'd4; ITCond = 4'd1;             // ignored while active
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);
    checks++;
    if ({MemWrite, ITActive} !== 2'b11) begin
      errors++; $display("FAIL it_restart_ign got=%b exp=11", {MemWrite, ITActive});
    end
    ITStart = 0;
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);
    checks++;
    if ({MemWrite, ITActive} !== 2'b10) begin
      errors++; $display("FAIL it_restart_end got=%b exp=10", {MemWrite, ITActive});
    end
  endtask

  task automatic test_it_stall_flush;
    clear_in();
    instr(4'd14, 2'b11, 4'b0100, 4'b0000);   // Z=1
    ITStart = 1; ITCond = 4'd0; ITLen = 3'd3; ITMask = 4'b0000;
    instr(4'd14, 2'b00, 4'b0000, 4'b0000);
    ITStart = 0;
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);   // remaining 3 -> 2
    Stall = 1; Valid = 1; {PCS, RegW, MemW, FPUW} = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({outs, ITActive} !== 7'b0010111) begin
        errors++; $display("FAIL it_stall cyc=%0d got=%b exp=0010111", i, {outs, ITActive});
      end
    end
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);   // remaining 2 -> 1
    checks++;
    if ({MemWrite, ITActive} !== 2'b11) begin
      errors++; $display("FAIL it_after_stall got=%b exp=11", {MemWrite, ITActive});
    end
    Flush = 1; Valid = 1;
    tick();
    checks++;
    if ({outs, ITActive} !== 7'b0000000) begin
      errors++; $display("FAIL it_flush got=%b exp=0000000", {outs, ITActive});
    end
    instr(4'd1, 2'b00, 4'b0000, 4'b0010);    // NE with Z=1: false
    checks++;
    if (outs !== 6'b000001) begin
      errors++; $display("FAIL it_post_flush got=%b exp=000001", outs);
    end
  endtask

  task automatic test_reset_mid_it;
    clear_in();
    instr(4'd14, 2'b11, 4'b0110, 4'b0000);   // Z=1, C=1
    ITStart = 1; ITCond = 4'd0; ITLen = 3'd4; ITMask = 4'b0000;
    instr(4'd14, 2'b00, 4'b0000, 4'b0000);
    ITStart = 0;
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);
    Reset = 1; Valid = 1;
    tick();
    checks++;
    if ({outs, ITActive, C} !== 8'b00000000) begin
      errors++; $display("FAIL it_reset got=%b exp=00000000", {outs, ITActive, C});
    end
    instr(4'd0, 2'b00, 4'b0000, 4'b0010);    // Z cleared, IDLE
    checks++;
    if ({outs, ITActive} !== 7'b0000010) begin
      errors++; $display("FAIL it_reset_after got=%b exp=0000010", {outs, ITActive});
    end
  endtask
`else
  task automatic test_it_disabled;
    clear_in();
    instr(4'd14, 2'b11, 4'b0100, 4'b0000);   // Z=1
    ITStart = 1; ITCond = 4'd0; ITLen = 3'd3; ITMask = 4'b0000;
    instr(4'd14, 2'b00, 4'b0000, 4'b0010);
    checks++;
    if ({outs, ITActive} !== 7'b0010110) begin
      errors++; $display("FAIL it_off_start got=%b exp=0010110", {outs, ITActive});
    end
    ITStart = 0;
    instr(4'd1, 2'b00, 4'b0000, 4'b0010);    // Cond used: NE false
    checks++;
    if ({outs, ITActive} !== 7'b0000010) begin
      errors++; $display("FAIL it_off_cond got=%b exp=0000010", {outs, ITActive});
    end
  endtask
`endif

  initial begin
    clear_in();
    test_reset();
    test_cond_basic();
    test_cond_table();
    test_false_no_flagwrite();
    test_fsel();
    test_stall_flush();
    test_back_to_back();
    test_reset_override();
`ifdef COND_IT_EN
    test_it_block();
    test_it_stall_flush();
    test_reset_mid_it();
`else
    test_it_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
